mul_wb_buffer: RTL and testbench
================================

MUL_WB_BUFFER -- requirements
Module: mul_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of result entries held (power of two, >=2).
REQ-002 SHALL have parameter RD_W, default 5, destination register index width.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  rising-edge clock for all state.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port tag_valid_i  in  1  multiply accepted by multiplier this cycle (mul_valid & mul_ready).
REQ-007 SHALL have port tag_rd_i  in  RD_W  destination register of accepted multiply.
REQ-008 SHALL have port mul_res_i  in  64  multiplier result.
REQ-009 SHALL have port mul_res_valid_i  in  1  multiplier result valid.
REQ-010 SHALL have port mul_res_ready_o  out  1  buffer can accept result.
REQ-011 SHALL have port flush_i  in  1  pipeline flush.
REQ-012 SHALL have port wb_valid_o  out  1  writeback entry valid.
REQ-013 SHALL have port wb_rd_o  out  RD_W  writeback destination.
REQ-014 SHALL have port wb_data_o  out  64  writeback data.
REQ-015 SHALL have port wb_ready_i  in  1  writeback port accepts entry.
REQ-016 SHALL have port proto_err_o  out  1  one-cycle pulse on result without pending tag or tag while pending.

Function
REQ-017 Tag FSM SHALL have states T_IDLE, T_PEND; T_IDLE->T_PEND on tag_valid_i, capturing tag_rd_i.
REQ-018 T_PEND->T_IDLE SHALL occur on result handshake (mul_res_valid_i & mul_res_ready_o); same-cycle new tag_valid_i SHALL re-enter T_PEND with new rd.
REQ-019 tag_valid_i in T_PEND without same-cycle result handshake SHALL pulse proto_err_o and overwrite the tag.
REQ-020 Result handshake in T_IDLE SHALL pulse proto_err_o and discard the result (no push).
REQ-021 Result handshake in T_PEND SHALL push {tag rd, mul_res_i} into FIFO unless tag rd == 0, in which case the result SHALL be consumed and dropped.
REQ-022 mul_res_ready_o SHALL equal (count < DEPTH) & ~flush_i, independent of wb_ready_i.
REQ-023 FIFO SHALL use read/write pointers wrapping modulo DEPTH and a count 0..DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-024 wb_valid_o SHALL equal (count != 0) & ~flush_i; wb_rd_o/wb_data_o SHALL present head entry, zero when empty.
REQ-025 Pop SHALL occur on wb_valid_o & wb_ready_i; outputs SHALL hold stable while wb_valid_o & ~wb_ready_i.
REQ-026 Latency without bypass: result accepted in cycle N SHALL appear on wb_valid_o in cycle N+1.
REQ-027 flush_i SHALL, next edge, empty FIFO (count=0, pointers 0) and return FSM to T_IDLE; flush wins over same-cycle push, pop and tag capture.
REQ-028 Sustained throughput SHALL be one result per cycle when wb_ready_i held high.

Reset
REQ-029 On reset: count=0, pointers=0, FSM=T_IDLE, tag rd=0.
REQ-030 Outputs during/after reset: wb_valid_o=0, wb_rd_o=0, wb_data_o=0, proto_err_o=0, mul_res_ready_o=1 (0 while reset asserted).
REQ-031 Reset asserted mid-operation SHALL discard all entries and pending tag without emitting them.

Configuration
REQ-032 Macro MUL_WB_BYPASS_EN defined: when count==0, T_PEND, rd!=0 and wb_ready_i, result SHALL pass to wb_* combinationally same cycle without entering FIFO.
REQ-033 Macro MUL_WB_BYPASS_EN undefined: no combinational path from mul_res_* to wb_*; REQ-026 latency applies to every result.

Structure
REQ-034 Shared package SHALL hold mul_wb_state_t (T_IDLE, T_PEND) and constant MUL_WB_DEPTH_DEF = 2.
REQ-035 FIFO storage and pointers SHALL be sub-module mul_wb_fifo (push, pop, flush, full, empty, count); tag FSM, drop and error logic in mul_wb_buffer.

Verification
REQ-036 Tag rd=5, result 0x1234 next cycle, wb_ready_i=1 -> wb_valid_o=1, wb_rd_o=5, wb_data_o=0x1234 one cycle later (same cycle with bypass).
REQ-037 wb_ready_i=0, three tagged results -> first two stored, mul_res_ready_o=0 after second, third stalls; wb_ready_i=1 -> drain in order rd 1,2,3.
REQ-038 Tag rd=0, result 0xFFFF -> result consumed, wb_valid_o stays 0, FSM T_IDLE.
REQ-039 Result valid with no tag -> proto_err_o pulses one cycle, count stays 0.
REQ-040 Two entries held, flush_i with simultaneous result push -> next cycle count=0, wb_valid_o=0, FSM T_IDLE, pushed result absent.
REQ-041 reset asserted with one entry held and tag pending -> after release wb_valid_o=0, mul_res_ready_o=1, FSM T_IDLE.

Source files
------------

// File: rtl/mul_wb_pkg.sv
// mul_wb_pkg: shared types and defaults for the multiplier writeback buffer.
package mul_wb_pkg;
  typedef enum logic {T_IDLE, T_PEND} mul_wb_state_t;
  localparam int MUL_WB_DEPTH_DEF = 2;
endpackage

// File: rtl/mul_wb_fifo.sv
// mul_wb_fifo: power-of-two FIFO with wrapping pointers, occupancy count and flush.
module mul_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign data_o = mem_q[rp_q];
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop = pop_i & ~empty_o & ~flush_i;
  always_comb begin
    wp_d = flush_i ? '0 : wp_q + PW'(do_push);
    rp_d = flush_i ? '0 : rp_q + PW'(do_pop);
    cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end
endmodule

// File: rtl/mul_wb_buffer.sv
// mul_wb_buffer: tags multiply results with their destination and queues them for writeback.
// Define MUL_WB_BYPASS_EN to forward a result straight to wb_* when the queue is empty.
module mul_wb_buffer import mul_wb_pkg::*; #(
  parameter int DEPTH = MUL_WB_DEPTH_DEF,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tag_valid_i,
  input  logic [RD_W-1:0] tag_rd_i,
  input  logic [63:0]     mul_res_i,
  input  logic            mul_res_valid_i,
  output logic            mul_res_ready_o,
  input  logic            flush_i,
  output logic            wb_valid_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic [63:0]     wb_data_o,
  input  logic            wb_ready_i,
  output logic            proto_err_o
);
  localparam int W = RD_W + 64;
  mul_wb_state_t state_q, state_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic err_q, err_d;
  logic live, res_hs, push, pop, byp, full, empty;
  logic [W-1:0] head;
  logic [$clog2(DEPTH+1)-1:0] fifo_cnt;
  assign live = ~flush_i & ~reset;
  assign mul_res_ready_o = ~full & live;
  assign res_hs = mul_res_valid_i & mul_res_ready_o;
`ifdef MUL_WB_BYPASS_EN
  assign byp = empty & (state_q == T_PEND) & (rd_q != '0) & wb_ready_i & res_hs;
`else
  assign byp = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= T_IDLE;
      rd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      err_q <= err_d;
    end
  end
  // A new tag in the handshake cycle re-arms the FSM for the next multiply.
  always_comb begin
    state_d = flush_i ? T_IDLE : (tag_valid_i | (state_q == T_PEND & ~res_hs)) ? T_PEND : T_IDLE;
    rd_d = flush_i ? '0 : tag_valid_i ? tag_rd_i : rd_q;
  end
  always_comb begin
    push = res_hs & (state_q == T_PEND) & (rd_q != '0) & ~byp;
    err_d = (res_hs & state_q == T_IDLE) | (tag_valid_i & state_q == T_PEND & ~res_hs);
  end
  assign pop = wb_valid_o & wb_ready_i & ~byp;
  assign wb_valid_o = ((fifo_cnt != '0) & live) | byp;
  assign wb_rd_o = byp ? rd_q : (empty | reset) ? '0 : head[W-1:64];
  assign wb_data_o = byp ? mul_res_i : (empty | reset) ? '0 : head[63:0];
  assign proto_err_o = err_q;
  mul_wb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push_i(push),
    .pop_i(pop),
    .flush_i(flush_i),
    .data_i({rd_q, mul_res_i}),
    .data_o(head),
    .full_o(full),
    .empty_o(empty),
    .count_o(fifo_cnt)
  );
endmodule

// File: tb/tb_mul_wb_buffer.sv
// tb_mul_wb_buffer: vector table plus corner-case sequences, with a writeback scoreboard.
module tb_mul_wb_buffer;
  import mul_wb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1, tag_valid_i = 1'b0, mul_res_valid_i = 1'b0, flush_i = 1'b0, wb_ready_i = 1'b0;
  logic [4:0] tag_rd_i = '0;
  logic [63:0] mul_res_i = '0;
  logic mul_res_ready_o, wb_valid_o, proto_err_o;
  logic [4:0] wb_rd_o;
  logic [63:0] wb_data_o;
  int tests = 0, fails = 0;

  typedef struct packed {logic [4:0] rd; logic [63:0] d;} ent_t;
  ent_t sb[$];

  typedef struct {
    logic tv; logic [4:0] trd; logic rv; logic [63:0] res; logic wr;
    logic push; logic [4:0] prd;
    logic e_rdy; logic e_v; logic [4:0] e_rd; logic [63:0] e_d; logic e_err;
  } vec_t;
  localparam int NV = 21;
  vec_t vt [NV];

  always #5 clk = ~clk;

  mul_wb_buffer dut (
    .clk(clk), .reset(reset), .tag_valid_i(tag_valid_i), .tag_rd_i(tag_rd_i),
    .mul_res_i(mul_res_i), .mul_res_valid_i(mul_res_valid_i), .mul_res_ready_o(mul_res_ready_o),
    .flush_i(flush_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_ready_i(wb_ready_i), .proto_err_o(proto_err_o)
  );

  function automatic vec_t mk(input logic tv, input logic [4:0] trd, input logic rv,
                              input logic [63:0] res, input logic wr, input logic push,
                              input logic [4:0] prd, input logic e_rdy, input logic e_v,
                              input logic [4:0] e_rd, input logic [63:0] e_d, input logic e_err);
    vec_t r;
    r.tv = tv; r.trd = trd; r.rv = rv; r.res = res; r.wr = wr; r.push = push; r.prd = prd;
    r.e_rdy = e_rdy; r.e_v = e_v; r.e_rd = e_rd; r.e_d = e_d; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  // One cycle: drive after the edge, then sample and score writebacks at the falling edge.
  task automatic drv(input logic rs, input logic tv, input logic [4:0] trd, input logic rv,
                     input logic [63:0] res, input logic wr, input logic fl);
    @(posedge clk);
    #1;
    reset = rs; tag_valid_i = tv; tag_rd_i = trd; mul_res_valid_i = rv;
    mul_res_i = res; wb_ready_i = wr; flush_i = fl;
    @(negedge clk);
    if (wb_valid_o && wb_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_extra: got rd=%0d data=%h want no writeback", wb_rd_o, wb_data_o);
      end else chk("sb_order", {wb_rd_o, wb_data_o}, sb.pop_front());
    end
  endtask

  initial begin
    vt[0]  = mk(0, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[1]  = mk(1, 5, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[2]  = mk(0, 0, 1, 'h1234,   1, 1, 5, 1, 0, 0, 0,        0);
    vt[3]  = mk(0, 0, 0, 0,        1, 0, 0, 1, 1, 5, 'h1234,   0);
    vt[4]  = mk(0, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[5]  = mk(0, 0, 1, 'hAAAA,   1, 0, 0, 1, 0, 0, 0,        0);
    vt[6]  = mk(0, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        1);
    vt[7]  = mk(0, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[8]  = mk(1, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[9]  = mk(0, 0, 1, 'hFFFF,   1, 0, 0, 1, 0, 0, 0,        0);
    vt[10] = mk(0, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[11] = mk(1, 3, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[12] = mk(1, 4, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[13] = mk(0, 0, 1, 'h44,     1, 1, 4, 1, 0, 0, 0,        1);
    vt[14] = mk(0, 0, 0, 0,        1, 0, 0, 1, 1, 4, 'h44,     0);
    vt[15] = mk(1, 7, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);
    vt[16] = mk(1, 8, 1, 'h70,     1, 1, 7, 1, 0, 0, 0,        0);
    vt[17] = mk(1, 9, 1, 'h80,     1, 1, 8, 1, 1, 7, 'h70,     0);
    vt[18] = mk(0, 0, 1, 'h90,     1, 1, 9, 1, 1, 8, 'h80,     0);
    vt[19] = mk(0, 0, 0, 0,        1, 0, 0, 1, 1, 9, 'h90,     0);
    vt[20] = mk(0, 0, 0, 0,        1, 0, 0, 1, 0, 0, 0,        0);

    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    chk("rst_active", {mul_res_ready_o, wb_valid_o, proto_err_o}, 3'b000);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("rst_outputs", {mul_res_ready_o, wb_valid_o, wb_rd_o, wb_data_o, proto_err_o}, {1'b1, 71'd0});
    chk("rst_state", dut.state_q, T_IDLE);

    for (int i = 0; i < NV; i++) begin
      if (vt[i].push) sb.push_back({vt[i].prd, vt[i].res});
      drv(0, vt[i].tv, vt[i].trd, vt[i].rv, vt[i].res, vt[i].wr, 0);
      chk($sformatf("vec%0d", i), {mul_res_ready_o, wb_valid_o, wb_rd_o, wb_data_o, proto_err_o},
          {vt[i].e_rdy, vt[i].e_v, vt[i].e_rd, vt[i].e_d, vt[i].e_err});
      if (i == 6) chk("err_count", dut.fifo_cnt, 0);
      if (i == 10) chk("rd0_idle", dut.state_q, T_IDLE);
    end

    // Backpressure: two stored, third stalls, then in-order drain.
    drv(0, 1, 1, 0, 0, 0, 0);
    sb.push_back({5'd1, 64'h11});
    drv(0, 1, 2, 1, 'h11, 0, 0);
    sb.push_back({5'd2, 64'h22});
    drv(0, 1, 3, 1, 'h22, 0, 0);
    chk("bp_rdy_one", mul_res_ready_o, 1);
    drv(0, 0, 0, 1, 'h33, 0, 0);
    chk("bp_rdy_full", mul_res_ready_o, 0);
    chk("bp_head", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd1, 64'h11});
    drv(0, 0, 0, 1, 'h33, 0, 0);
    chk("bp_hold", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd1, 64'h11});
    drv(0, 0, 0, 1, 'h33, 1, 0);
    chk("bp_rdy_indep", mul_res_ready_o, 0);
    sb.push_back({5'd3, 64'h33});
    drv(0, 0, 0, 1, 'h33, 1, 0);
    chk("bp_rdy_pop", {mul_res_ready_o, wb_rd_o}, {1'b1, 5'd2});
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("bp_last", {wb_valid_o, wb_rd_o}, {1'b1, 5'd3});
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("bp_drained", wb_valid_o, 0);

    // Flush with two held and a result offered in the same cycle.
    drv(0, 1, 1, 0, 0, 0, 0);
    sb.push_back({5'd1, 64'hA1});
    drv(0, 1, 2, 1, 'hA1, 0, 0);
    sb.push_back({5'd2, 64'hA2});
    drv(0, 1, 3, 1, 'hA2, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("fl_two", dut.fifo_cnt, 2);
    sb.delete();
    drv(0, 0, 0, 1, 'hA3, 1, 1);
    chk("fl_during", {mul_res_ready_o, wb_valid_o}, 2'b00);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("fl_after", {dut.fifo_cnt, wb_valid_o, dut.state_q}, {2'd0, 1'b0, T_IDLE});
    drv(0, 1, 4, 0, 0, 1, 0);
    sb.push_back({5'd4, 64'hB4});
    drv(0, 0, 0, 1, 'hB4, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("fl_resume", {wb_valid_o, wb_rd_o, wb_data_o, proto_err_o}, {1'b1, 5'd4, 64'hB4, 1'b0});

    // Reset mid-operation with an entry held and a tag pending.
    drv(0, 1, 1, 0, 0, 0, 0);
    sb.push_back({5'd1, 64'hC1});
    drv(0, 1, 2, 1, 'hC1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("mr_held", {dut.fifo_cnt, wb_valid_o}, {2'd1, 1'b1});
    sb.delete();
    drv(1, 0, 0, 0, 0, 1, 0);
    chk("mr_during", {mul_res_ready_o, wb_valid_o}, 2'b00);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("mr_after", {mul_res_ready_o, wb_valid_o, wb_rd_o, wb_data_o, proto_err_o}, {1'b1, 71'd0});
    chk("mr_state", dut.state_q, T_IDLE);
    drv(0, 0, 0, 1, 'hD1, 1, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("mr_notag_err", {proto_err_o, wb_valid_o}, 2'b10);
    drv(0, 0, 0, 0, 0, 1, 0);
    chk("mr_err_pulse", proto_err_o, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
